flght_cntrl_pid: RTL
====================

# flght_cntrl_pid

Parametrised next-generation flight-control math block: it adds an integral term with clamp and ground reset to the PD controller, and registers the pipeline with a valid strobe. For pitch, roll and yaw it forms error, P, I and D terms from desired and actual attitude, then mixes them with thrust into four saturated 11-bit motor speeds. It sits between the inertial interface / cmd_cfg and the ESC interfaces. Depth, gains and widths are parameters; the motor mixing is fixed quad-X.

## Interface
- D_QUEUE_DEPTH, 14: vld samples between the D-term difference endpoints (min 2).
- D_COEFF, 7: signed D gain applied to the saturated D difference.
- D_W, 6: signed width the D difference saturates to.
- I_W, 16: signed integrator width per axis.
- I_LIM, 16383: integrator clamps to ±I_LIM.
- I_SHIFT, 4: I term = integrator >>> I_SHIFT.
- CAL_SPEED, 11'h1B0: motor speed during inertial calibration.
- MIN_RUN_SPEED, 13'h200: base speed added to every motor.
- clk input 1: clock.
- rst_n input 1: reset, asynchronous, active-low.
- vld input 1: new inertial reading; single-cycle strobe.
- inertial_cal input 1: calibration in progress.
- d_ptch, d_roll, d_yaw input 16 signed: desired attitude.
- ptch, roll, yaw input 16 signed: measured attitude.
- thrst input 9 unsigned: thrust.
- frnt_spd, bck_spd, lft_spd, rght_spd output 11 unsigned: registered motor speeds.
- spd_vld output 1: one-cycle strobe when new speeds are presented.
- sat output 1: registered; 1 when any motor sum was clipped (low or high) in the last update.

## Operation
- Error: err = actual − desired in 17 bits, then signed-saturate to 10 bits, range −512..511.
- D queue:
  - Per axis: D_QUEUE_DEPTH × 10-bit shift register.
  - Shifts only on vld; q[0] ← err_sat.
  - D_diff = q[0] − q[DEPTH−1] in 10 bits, signed-saturated to D_W bits.
  - Dterm = D_COEFF × D_diff_sat, 12 bits signed.
- P term: Pterm = (err_sat >>> 1) + (err_sat >>> 3), i.e. 5/8 gain, arithmetic shifts.
- Integrator, per axis, I_W bits:
  - On vld: integ ← clamp(integ + sext(err_sat), −I_LIM, +I_LIM).
  - Cleared to 0 on any cycle where inertial_cal = 1 or thrst = 0; clear has priority over accumulate.
  - Iterm = integ >>> I_SHIFT.
- Mix, 13-bit signed, base B = MIN_RUN_SPEED + thrst:
  - frnt = B − Pp − Dp − Ip − Py − Dy − Iy.
  - bck = B + Pp + Dp + Ip − Py − Dy − Iy.
  - lft = B − Pr − Dr − Ir + Py + Dy + Iy.
  - rght = B + Pr + Dr + Ir + Py + Dy + Iy.
- Output saturation: sum < 0 → 0; sum > 2047 → 2047; either case sets sat.
- Calibration:
  - inertial_cal = 1: all four speeds register CAL_SPEED every cycle, vld or not.
  - D queues and integrators are held at 0; sat = 0.
  - spd_vld still pulses for each vld.
- Reset: all queues, integrators, pipeline registers, speeds, sat and spd_vld go to 0 immediately. There is no recovery from a partially processed sample.

## Timing
- Stage 1, edge k with vld = 1: err_sat, queue shift and integrator update.
- Stage 2, edge k+1: P, I, D terms registered from the stage-1 state.
- Stage 3, edge k+2: the four speeds and sat register, and spd_vld pulses high for exactly one cycle.
- Back-to-back vld on every cycle is supported at full throughput.
- Speeds hold their value between updates.
- With inertial_cal, CAL_SPEED appears one edge after the cal assertion.
- On cal deassertion, normal values return with the next vld result.
- vld and a clear condition in the same cycle: the integrator is 0 after the edge.

## Test plan
- Zero error: thrst = 0x100, all attitudes 0, vld pulse → at edge k+2 all speeds = 0x300, spd_vld = 1 for 1 cycle, sat = 0.
- Pitch step: ptch = 0x40, thrst = 0x100, first vld → P = 40, D = 7×31 = 217, I = 4; frnt = 0x1FB, bck = 0x405, lft/rght = 0x300.
- D queue depth: hold ptch = 0x40 for 20 vlds → D = 217 for results 1–13, D = 0 from result 14 on.
- Error saturation and low clip: ptch = 0x7FFF, d_ptch = 0x8000, thrst = 0 → err_sat = 511, P = 318, I = 0; frnt = 0 with sat = 1, bck = 1047.
- Integrator clamp: err = +511, thrst = 0x100, 40 vlds → integ = 16352 after vld 32 and 16383 from vld 33 on; bck = 2047, frnt = 0, sat = 1.
- Calibration and reset: assert inertial_cal mid-stream → next edge all speeds = 0x1B0 and integrators = 0; pulse rst_n low between vld and spd_vld → outputs 0 and no spd_vld pulse.

Source files
------------

// File: rtl/flght_cntrl_pid_if.sv
// Inertial/command inputs and motor speed outputs of the flight-control PID mixer.
interface flght_cntrl_pid_if;
  logic               vld;
  logic               inertial_cal;
  logic signed [15:0] d_ptch;
  logic signed [15:0] d_roll;
  logic signed [15:0] d_yaw;
  logic signed [15:0] ptch;
  logic signed [15:0] roll;
  logic signed [15:0] yaw;
  logic        [8:0]  thrst;
  logic        [10:0] frnt_spd;
  logic        [10:0] bck_spd;
  logic        [10:0] lft_spd;
  logic        [10:0] rght_spd;
  logic               spd_vld;
  logic               sat;

  modport master (
    output vld, inertial_cal, d_ptch, d_roll, d_yaw, ptch, roll, yaw, thrst,
    input  frnt_spd, bck_spd, lft_spd, rght_spd, spd_vld, sat
  );

  modport slave (
    input  vld, inertial_cal, d_ptch, d_roll, d_yaw, ptch, roll, yaw, thrst,
    output frnt_spd, bck_spd, lft_spd, rght_spd, spd_vld, sat
  );
endinterface

// File: rtl/flght_cntrl_pid.sv
// Three-stage PID controller for pitch/roll/yaw mixed with thrust into quad-X motor speeds.
// Axis index 0/1/2 = pitch/roll/yaw; motor index 0..3 = front/back/left/right.
module flght_cntrl_pid #(
  parameter int          D_QUEUE_DEPTH = 14,
  parameter int          D_COEFF       = 7,
  parameter int          D_W           = 6,
  parameter int          I_W           = 16,
  parameter int          I_LIM         = 16383,
  parameter int          I_SHIFT       = 4,
  parameter logic [10:0] CAL_SPEED     = 11'h1B0,
  parameter logic [12:0] MIN_RUN_SPEED = 13'h200
) (
  input logic              clk,
  input logic              rst_n,
  flght_cntrl_pid_if.slave bus
);

  // Mix width leaves headroom so the clip sees the true sum rather than a wrapped one.
  localparam int                    MW       = I_W + 3;
  localparam int                    DMAXI    = (1 << (D_W - 1)) - 1;
  localparam int                    SPDMAXI  = 2047;
  localparam logic signed [9:0]     DQ_MAX   = DMAXI[9:0];
  localparam logic signed [9:0]     DQ_MIN   = -DQ_MAX - 10'sd1;
  localparam logic signed [I_W:0]   INT_MAX  = I_LIM[I_W:0];
  localparam logic signed [I_W:0]   INT_MIN  = -INT_MAX;
  localparam logic signed [11:0]    DCOEF    = D_COEFF[11:0];
  localparam logic signed [MW-1:0]  SPD_MAX  = SPDMAXI[MW-1:0];
  localparam logic signed [16:0]    ERR_MIN  = -17'sd512;

  function automatic logic signed [9:0] sat_err(input logic signed [16:0] v);
    if (v > 17'sd511) return 10'sd511;
    if (v < ERR_MIN)  return 10'sh200;
    return v[9:0];
  endfunction

  function automatic logic signed [D_W-1:0] sat_dq(input logic signed [9:0] v);
    if (v > DQ_MAX) return DQ_MAX[D_W-1:0];
    if (v < DQ_MIN) return DQ_MIN[D_W-1:0];
    return v[D_W-1:0];
  endfunction

  logic signed [15:0]    act [3];
  logic signed [15:0]    des [3];
  logic signed [9:0]     err_sat [3];
  logic signed [I_W:0]   integ_sum [3];
  logic signed [I_W-1:0] integ_d [3];
  logic signed [I_W-1:0] integ_q [3];
  logic signed [9:0]     dq_q [3][D_QUEUE_DEPTH];
  logic                  v1_q;
  logic        [8:0]     thr1_q;

  assign act[0] = bus.ptch;
  assign act[1] = bus.roll;
  assign act[2] = bus.yaw;
  assign des[0] = bus.d_ptch;
  assign des[1] = bus.d_roll;
  assign des[2] = bus.d_yaw;

  always_comb begin
    for (int a = 0; a < 3; a++) begin
      err_sat[a]   = sat_err($signed({act[a][15], act[a]}) - $signed({des[a][15], des[a]}));
      integ_sum[a] = $signed({integ_q[a][I_W-1], integ_q[a]})
                   + $signed({{(I_W-9){err_sat[a][9]}}, err_sat[a]});
      integ_d[a]   = integ_q[a];
      // Clear wins over accumulate, and applies on every cycle, not only on vld.
      if (bus.inertial_cal || bus.thrst == '0) integ_d[a] = '0;
      else if (bus.vld) begin
        if (integ_sum[a] > INT_MAX)      integ_d[a] = INT_MAX[I_W-1:0];
        else if (integ_sum[a] < INT_MIN) integ_d[a] = INT_MIN[I_W-1:0];
        else                             integ_d[a] = integ_sum[a][I_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      thr1_q <= '0;
      for (int a = 0; a < 3; a++) begin
        integ_q[a] <= '0;
        for (int i = 0; i < D_QUEUE_DEPTH; i++) dq_q[a][i] <= '0;
      end
    end else begin
      v1_q <= bus.vld;
      if (bus.vld) thr1_q <= bus.thrst;
      for (int a = 0; a < 3; a++) begin
        integ_q[a] <= integ_d[a];
        if (bus.inertial_cal) begin
          for (int i = 0; i < D_QUEUE_DEPTH; i++) dq_q[a][i] <= '0;
        end else if (bus.vld) begin
          dq_q[a][0] <= err_sat[a];
          for (int i = 1; i < D_QUEUE_DEPTH; i++) dq_q[a][i] <= dq_q[a][i-1];
        end
      end
    end
  end

  logic signed [9:0]     p_d [3];
  logic signed [9:0]     d_diff [3];
  logic signed [D_W-1:0] d_sat [3];
  logic signed [11:0]    d_d [3];
  logic signed [I_W-1:0] i_d [3];
  logic signed [9:0]     p_q [3];
  logic signed [11:0]    d_q [3];
  logic signed [I_W-1:0] i_q [3];
  logic                  v2_q;
  logic        [8:0]     thr2_q;

  always_comb begin
    for (int a = 0; a < 3; a++) begin
      p_d[a]    = (dq_q[a][0] >>> 1) + (dq_q[a][0] >>> 3);
      d_diff[a] = dq_q[a][0] - dq_q[a][D_QUEUE_DEPTH-1];
      d_sat[a]  = sat_dq(d_diff[a]);
      d_d[a]    = DCOEF * 12'(d_sat[a]);
      i_d[a]    = integ_q[a] >>> I_SHIFT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q   <= 1'b0;
      thr2_q <= '0;
      for (int a = 0; a < 3; a++) begin
        p_q[a] <= '0;
        d_q[a] <= '0;
        i_q[a] <= '0;
      end
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        thr2_q <= thr1_q;
        for (int a = 0; a < 3; a++) begin
          p_q[a] <= p_d[a];
          d_q[a] <= d_d[a];
          i_q[a] <= i_d[a];
        end
      end
    end
  end

  logic signed [MW-1:0] base;
  logic signed [MW-1:0] ax [3];
  logic signed [MW-1:0] sum_d [4];
  logic        [10:0]   spd_d [4];
  logic                 sat_d;
  logic        [10:0]   spd_q [4];
  logic                 sat_q;
  logic                 spd_vld_q;

  always_comb begin
    base = $signed({{(MW-13){1'b0}}, MIN_RUN_SPEED}) + $signed({{(MW-9){1'b0}}, thr2_q});
    for (int a = 0; a < 3; a++) ax[a] = MW'(p_q[a]) + MW'(d_q[a]) + MW'(i_q[a]);
    sum_d[0] = base - ax[0] - ax[2];
    sum_d[1] = base + ax[0] - ax[2];
    sum_d[2] = base - ax[1] + ax[2];
    sum_d[3] = base + ax[1] + ax[2];
    sat_d    = 1'b0;
    for (int m = 0; m < 4; m++) begin
      spd_d[m] = sum_d[m][10:0];
      if (sum_d[m][MW-1]) begin
        spd_d[m] = '0;
        sat_d    = 1'b1;
      end else if (sum_d[m] > SPD_MAX) begin
        spd_d[m] = 11'h7FF;
        sat_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spd_vld_q <= 1'b0;
      sat_q     <= 1'b0;
      for (int m = 0; m < 4; m++) spd_q[m] <= '0;
    end else begin
      spd_vld_q <= v2_q;
      if (bus.inertial_cal) begin
        sat_q <= 1'b0;
        for (int m = 0; m < 4; m++) spd_q[m] <= CAL_SPEED;
      end else if (v2_q) begin
        sat_q <= sat_d;
        for (int m = 0; m < 4; m++) spd_q[m] <= spd_d[m];
      end
    end
  end

  assign bus.frnt_spd = spd_q[0];
  assign bus.bck_spd  = spd_q[1];
  assign bus.lft_spd  = spd_q[2];
  assign bus.rght_spd = spd_q[3];
  assign bus.sat      = sat_q;
  assign bus.spd_vld  = spd_vld_q;

endmodule
